// File: rtl/cpu_pkg.sv
// Definitions shared by instruction decode, the operand stack and the ALU:
// datapath width, stack command encodings and ALU op codes.
package cpu_pkg;

  localparam int WIDTH = 16;

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_PUSH   = 3'b001;
  localparam logic [2:0] CMD_POP    = 3'b010;
  localparam logic [2:0] CMD_REDUCE = 3'b011;
  localparam logic [2:0] CMD_DUP    = 3'b100;
  localparam logic [2:0] CMD_SWAP   = 3'b101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH stack storage: two combinational read ports (TOS/NOS) and two
// write ports so SWAP can exchange both entries in one edge. No reset on storage.
module stack_regfile #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_a,
  input  logic [AW-1:0]    waddr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             we_b,
  input  logic [AW-1:0]    waddr_b,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic [AW-1:0]    raddr_tos,
  input  logic [AW-1:0]    raddr_nos,
  output logic [WIDTH-1:0] rdata_tos,
  output logic [WIDTH-1:0] rdata_nos
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Port B is only used by SWAP, whose two addresses always differ.
  always_comb begin
    mem_d = mem_q;
    if (we_a) mem_d[waddr_a] = wdata_a;
    if (we_b) mem_d[waddr_b] = wdata_b;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata_tos = mem_q[raddr_tos];
  assign rdata_nos = mem_q[raddr_nos];

endmodule

// File: rtl/operand_stack.sv
// Operand stack feeding the ALU: exposes NOS/TOS as operands, absorbs the ALU
// result on REDUCE, and tracks saturating pointer plus sticky error flags.
module operand_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             cmd_done
);

  localparam int AW = $clog2(DEPTH);

  // cmd/push_data are taken on every rising edge where cmd_valid is high; there
  // is no ready, every command finishes in that edge and cmd_done follows it.
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             cmd_done_q, cmd_done_d;

  logic [CW-1:0]    tos_ptr, nos_ptr;
  logic [AW-1:0]    tos_idx, nos_idx, push_idx;
  logic [WIDTH-1:0] tos_raw, nos_raw;
  logic             is_full;

  logic             we_a, we_b;
  logic [AW-1:0]    waddr_a, waddr_b;
  logic [WIDTH-1:0] wdata_a, wdata_b;

  assign tos_ptr  = count_q - CW'(1);
  assign nos_ptr  = count_q - CW'(2);
  assign tos_idx  = tos_ptr[AW-1:0];
  assign nos_idx  = nos_ptr[AW-1:0];
  assign push_idx = count_q[AW-1:0];
  assign is_full  = (count_q == CW'(DEPTH));

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    cmd_done_d  = 1'b0;
    we_a        = 1'b0;
    waddr_a     = push_idx;
    wdata_a     = push_data;
    we_b        = 1'b0;
    waddr_b     = nos_idx;
    wdata_b     = tos_raw;
    if (cmd_valid) begin
      case (cmd)
        CMD_PUSH: begin
          if (!is_full) begin
            we_a       = 1'b1;
            count_d    = count_q + CW'(1);
            cmd_done_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        CMD_POP: begin
          if (count_q >= CW'(1)) begin
            count_d    = count_q - CW'(1);
            cmd_done_d = 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end
        CMD_REDUCE: begin
          if (count_q >= CW'(2)) begin
            we_a       = 1'b1;
            waddr_a    = nos_idx;
            wdata_a    = alu_result;
            count_d    = count_q - CW'(1);
            cmd_done_d = 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end
        CMD_DUP: begin
          // An empty stack has nothing to copy, so that case is an underflow.
          if (count_q == '0) begin
            underflow_d = 1'b1;
          end else if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            we_a       = 1'b1;
            wdata_a    = tos_raw;
            count_d    = count_q + CW'(1);
            cmd_done_d = 1'b1;
          end
        end
        CMD_SWAP: begin
          if (count_q >= CW'(2)) begin
            we_a       = 1'b1;
            waddr_a    = tos_idx;
            wdata_a    = nos_raw;
            we_b       = 1'b1;
            cmd_done_d = 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      cmd_done_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      cmd_done_q  <= cmd_done_d;
    end
  end

  // Writes are suppressed under reset so a colliding command leaves no trace.
  stack_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .we_a      (we_a & ~reset),
    .waddr_a   (waddr_a),
    .wdata_a   (wdata_a),
    .we_b      (we_b & ~reset),
    .waddr_b   (waddr_b),
    .wdata_b   (wdata_b),
    .raddr_tos (tos_idx),
    .raddr_nos (nos_idx),
    .rdata_tos (tos_raw),
    .rdata_nos (nos_raw)
  );

  assign operand2  = (count_q != '0)       ? tos_raw : '0;
  assign operand1  = (count_q >= CW'(2))   ? nos_raw : '0;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign cmd_done  = cmd_done_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack with a small combinational ALU model in the
// loop; every expected value below is a hand-computed constant.
module tb_operand_stack;
  import cpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [W-1:0]  push_data;
  logic [W-1:0]  alu_result;
  logic [W-1:0]  operand1, operand2;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow, cmd_done;
  logic [2:0]    alu_op;

  int n_cmp = 0;
  int n_err = 0;

  operand_stack #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .push_data  (push_data),
    .alu_result (alu_result),
    .operand1   (operand1),
    .operand2   (operand2),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow),
    .cmd_done   (cmd_done)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Combinational ALU stand-in driven by the stack's own operands.
  always_comb begin
    case (alu_op)
      ALU_SUB: alu_result = operand1 - operand2;
      ALU_AND: alu_result = operand1 & operand2;
      ALU_OR:  alu_result = operand1 | operand2;
      ALU_XOR: alu_result = operand1 ^ operand2;
      default: alu_result = operand1 + operand2;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one command for one rising edge, leave outputs settled #1 after.
  task automatic step(input logic [2:0] c, input logic [W-1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    push_data = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    push_data = '0;
    alu_op    = ALU_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_done", 32'(cmd_done), 0);
    chk("rst_op1", 32'(operand1), 0);
    chk("rst_op2", 32'(operand2), 0);
    @(negedge clk);
    reset = 1'b0;

    // 7 - 3 via REDUCE with SUB
    alu_op = ALU_SUB;
    step(CMD_PUSH, 16'h0007);
    chk("t1_push1_done", 32'(cmd_done), 1);
    chk("t1_push1_count", 32'(count), 1);
    chk("t1_push1_op2", 32'(operand2), 32'h0007);
    chk("t1_push1_op1", 32'(operand1), 0);
    step(CMD_PUSH, 16'h0003);
    chk("t1_push2_done", 32'(cmd_done), 1);
    chk("t1_push2_count", 32'(count), 2);
    chk("t1_push2_op1", 32'(operand1), 32'h0007);
    chk("t1_push2_op2", 32'(operand2), 32'h0003);
    step(CMD_NOP, 16'h0000);
    chk("t1_nop_done", 32'(cmd_done), 0);
    step(CMD_REDUCE, 16'h0000);
    chk("t1_red_count", 32'(count), 1);
    chk("t1_red_op2", 32'(operand2), 32'h0004);
    chk("t1_red_op1", 32'(operand1), 0);
    chk("t1_red_done", 32'(cmd_done), 1);

    // ADD wrap inside the ALU
    do_reset();
    alu_op = ALU_ADD;
    step(CMD_PUSH, 16'hFFFF);
    step(CMD_PUSH, 16'h0001);
    step(CMD_REDUCE, 16'h0000);
    chk("t2_op2", 32'(operand2), 32'h0000);
    chk("t2_count", 32'(count), 1);
    chk("t2_ovf", 32'(overflow), 0);
    chk("t2_unf", 32'(underflow), 0);

    // Fill to DEPTH, then overflow
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step(CMD_PUSH, W'(i));
    chk("t3_full", 32'(full), 1);
    chk("t3_count", 32'(count), 8);
    chk("t3_op1", 32'(operand1), 32'h0007);
    step(CMD_PUSH, 16'h00AA);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_ovf_count", 32'(count), 8);
    chk("t3_ovf_op2", 32'(operand2), 32'h0008);
    chk("t3_ovf_done", 32'(cmd_done), 0);
    chk("t3_ovf_unf", 32'(underflow), 0);
    step(CMD_POP, 16'h0000);
    chk("t3_pop_count", 32'(count), 7);
    chk("t3_pop_op2", 32'(operand2), 32'h0007);
    chk("t3_pop_full", 32'(full), 0);
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // Underflow from empty, then sticky
    do_reset();
    step(CMD_POP, 16'h0000);
    chk("t4_unf", 32'(underflow), 1);
    chk("t4_count", 32'(count), 0);
    chk("t4_empty", 32'(empty), 1);
    chk("t4_done", 32'(cmd_done), 0);
    step(CMD_PUSH, 16'h0005);
    chk("t4_push_count", 32'(count), 1);
    chk("t4_unf_sticky", 32'(underflow), 1);
    chk("t4_push_op2", 32'(operand2), 32'h0005);
    step(CMD_REDUCE, 16'h0000);
    chk("t4_red1_count", 32'(count), 1);
    chk("t4_red1_done", 32'(cmd_done), 0);
    chk("t4_red1_op2", 32'(operand2), 32'h0005);

    // DUP at count 0 is an underflow
    do_reset();
    step(CMD_DUP, 16'h0000);
    chk("t4b_dup0_unf", 32'(underflow), 1);
    chk("t4b_dup0_ovf", 32'(overflow), 0);
    chk("t4b_dup0_count", 32'(count), 0);

    // SWAP then DUP
    do_reset();
    step(CMD_PUSH, 16'h1111);
    step(CMD_PUSH, 16'h2222);
    step(CMD_SWAP, 16'h0000);
    chk("t5_swap_op1", 32'(operand1), 32'h2222);
    chk("t5_swap_op2", 32'(operand2), 32'h1111);
    chk("t5_swap_count", 32'(count), 2);
    chk("t5_swap_done", 32'(cmd_done), 1);
    step(CMD_DUP, 16'h0000);
    chk("t5_dup_count", 32'(count), 3);
    chk("t5_dup_op2", 32'(operand2), 32'h1111);
    chk("t5_dup_op1", 32'(operand1), 32'h1111);

    // Reset colliding with a PUSH: reset wins
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd       = CMD_PUSH;
    push_data = 16'hBEEF;
    @(posedge clk);
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_unf", 32'(underflow), 0);
    chk("t6_done", 32'(cmd_done), 0);
    chk("t6_op1", 32'(operand1), 0);
    chk("t6_op2", 32'(operand2), 0);
    @(negedge clk);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    step(CMD_PUSH, 16'h0042);
    step(3'b111, 16'h0099);
    chk("t6_rsv_count", 32'(count), 1);
    chk("t6_rsv_op2", 32'(operand2), 32'h0042);
    chk("t6_rsv_done", 32'(cmd_done), 0);
    chk("t6_rsv_flags", 32'({overflow, underflow}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
